holdreg_mq: RTL and testbench

- Parametrised successor to the calc1 single-entry hold register.
- Captures two-cycle operand requests (cmd + data1 in cycle t, data2 in cycle t+1) independently on NUM_PORTS requester ports.
- Buffers each completed request in a per-port FIFO of depth DEPTH and presents the head entry to downstream priority logic through a request/pop handshake.
- Adds what the single-entry block lacks: backpressure (busy), sticky protocol/overflow error flags, and generic width/depth/port count.

---
 rtl/holdreg_mq_pkg.sv | 23 ++
 rtl/holdreg_mq_if.sv | 34 +++
 rtl/holdreg_mq_port.sv | 156 +++++++++++++++
 rtl/holdreg_mq.sv | 58 +++++
 tb/tb_holdreg_mq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/holdreg_mq_pkg.sv
// rtl/holdreg_mq_pkg.sv - shared types and constants for the holdreg_mq hold register
//
// Purpose : command encoding, per-port FSM state encoding and entry-record
//           width helper shared by the holdreg_mq files.
// Ports   : none (package).
package holdreg_pkg;

  // A command value of zero means "no request on this port this cycle".
  localparam int unsigned CMD_NOP = 0;

  // Per-port capture FSM: IDLE waits for cmd+data1, OP2 takes data2.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } port_state_e;

  // One FIFO entry holds {cmd, data1, data2}.
  function automatic int unsigned entry_w(input int unsigned cmd_w,
                                          input int unsigned data_w);
    return cmd_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/holdreg_mq_if.sv
// rtl/holdreg_mq_if.sv - request/hold bus bundle between requesters, holdreg_mq and priority logic
//
// Purpose : groups the flattened per-port request, head and pop buses.
// Signals : req_cmd_in/req_data_in/hold_pop driven by the master side;
//           req_busy/hold_prio_req/hold_cmd/hold_data1/hold_data2/err_flag
//           driven by the holdreg_mq (slave) side. Port p occupies slice
//           [p*W +: W] of each flattened bus.
interface holdreg_mq_if #(
  parameter int NUM_PORTS = 4,
  parameter int CMD_W     = 4,
  parameter int DATA_W    = 32
);

  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS-1:0]        req_busy;
  logic [NUM_PORTS-1:0]        hold_prio_req;
  logic [NUM_PORTS*CMD_W-1:0]  hold_cmd;
  logic [NUM_PORTS*DATA_W-1:0] hold_data1;
  logic [NUM_PORTS*DATA_W-1:0] hold_data2;
  logic [NUM_PORTS-1:0]        hold_pop;
  logic [NUM_PORTS-1:0]        err_flag;

  modport master (
    output req_cmd_in, req_data_in, hold_pop,
    input  req_busy, hold_prio_req, hold_cmd, hold_data1, hold_data2, err_flag
  );

  modport slave (
    input  req_cmd_in, req_data_in, hold_pop,
    output req_busy, hold_prio_req, hold_cmd, hold_data1, hold_data2, err_flag
  );

endinterface

// File: rtl/holdreg_mq_port.sv
// rtl/holdreg_mq_port.sv - one requester port: two-cycle capture FSM, staging register, FIFO, error flag
//
// Purpose : captures cmd+data1 then data2, pushes the completed entry into a
//           DEPTH-entry FIFO and presents the head to downstream logic.
// Ports   : c_clk, reset (async active-high)
//           cmd_in, data_in     - request command / operand bus
//           busy                - cannot accept a new command this cycle
//           pop                 - downstream consumes the head entry
//           head_valid, head_cmd, head_data1, head_data2 - FIFO head (0 when empty)
//           err                 - sticky protocol/overflow error
module holdreg_port
  import holdreg_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  input  logic              pop,
  output logic              head_valid,
  output logic [CMD_W-1:0]  head_cmd,
  output logic [DATA_W-1:0] head_data1,
  output logic [DATA_W-1:0] head_data2,
  output logic              err
);

  localparam int ENTRY_W = int'(entry_w(CMD_W, DATA_W));
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  port_state_e              state_q, state_d;
  logic [CMD_W-1:0]         cmd_stg_q, cmd_stg_d;
  logic [DATA_W-1:0]        d1_stg_q, d1_stg_d;
  logic [ENTRY_W-1:0]       mem_q [DEPTH];
  logic [ENTRY_W-1:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     err_q, err_d;

  logic                     cmd_req;
  logic                     push_ok;
  logic                     pop_ok;
  logic [CNT_W:0]           occupancy;
  logic [ENTRY_W-1:0]       head_entry;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign cmd_req = (cmd_in != CMD_W'(CMD_NOP));

  // An in-flight capture already owns a slot, so it counts toward occupancy.
  // Built from registers only: a pop in this cycle does not free the slot
  // until the next cycle, which keeps hold_pop off any combinational path.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, (state_q == ST_OP2)};
  assign busy      = (occupancy >= (CNT_W + 1)'(DEPTH));

  assign pop_ok    = pop && (count_q != '0);

  always_comb begin
    state_d   = state_q;
    cmd_stg_d = cmd_stg_q;
    d1_stg_d  = d1_stg_q;
    err_d     = err_q;
    push_ok   = 1'b0;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_req) begin
          if (busy) begin
            // No slot for this request: drop it and remember the loss.
            err_d = 1'b1;
          end else begin
            cmd_stg_d = cmd_in;
            d1_stg_d  = data_in;
            state_d   = ST_OP2;
          end
        end
      end
      ST_OP2: begin
        // The operand bus carries data2 this cycle whatever the cmd bus says;
        // a non-zero cmd here is a requester protocol violation, not a request.
        state_d = ST_IDLE;
        if (cmd_req) begin
          err_d = 1'b1;
        end
        // Entering OP2 reserved a slot, so this guard only protects against
        // an impossible overflow.
        if (count_q < CNT_W'(DEPTH)) begin
          push_ok = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_ok) begin
      mem_d[wr_ptr_q] = {cmd_stg_q, d1_stg_q, data_in};
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_stg_q <= '0;
      d1_stg_q  <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cmd_stg_q <= cmd_stg_d;
      d1_stg_q  <= d1_stg_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  // Empty FIFO presents zeros rather than the stale last entry.
  assign head_valid = (count_q != '0);
  assign head_entry = head_valid ? mem_q[rd_ptr_q] : '0;
  assign head_cmd   = head_entry[ENTRY_W-1 -: CMD_W];
  assign head_data1 = head_entry[2*DATA_W-1 -: DATA_W];
  assign head_data2 = head_entry[DATA_W-1:0];
  assign err        = err_q;

endmodule

// File: rtl/holdreg_mq.sv
// rtl/holdreg_mq.sv - multi-port two-cycle operand hold register with per-port FIFOs
//
// Purpose : replicates holdreg_port NUM_PORTS times and slices the flattened
//           request/head buses of the interface between the instances.
// Ports   : c_clk  - sole clock, rising edge
//           reset  - asynchronous active-high, clears all state
//           bus    - holdreg_mq_if slave: req_cmd_in, req_data_in, req_busy,
//                    hold_prio_req, hold_cmd, hold_data1, hold_data2,
//                    hold_pop, err_flag
module holdreg_mq
  import holdreg_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int CMD_W     = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2
) (
  input  logic           c_clk,
  input  logic           reset,
  holdreg_mq_if.slave    bus
);

  logic [NUM_PORTS-1:0]        busy_w;
  logic [NUM_PORTS-1:0]        prio_w;
  logic [NUM_PORTS-1:0]        err_w;
  logic [NUM_PORTS*CMD_W-1:0]  cmd_w;
  logic [NUM_PORTS*DATA_W-1:0] d1_w;
  logic [NUM_PORTS*DATA_W-1:0] d2_w;

  // Ports are fully independent; no ordering or arbitration between them.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    holdreg_port #(
      .CMD_W  (CMD_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .c_clk      (c_clk),
      .reset      (reset),
      .cmd_in     (bus.req_cmd_in[p*CMD_W +: CMD_W]),
      .data_in    (bus.req_data_in[p*DATA_W +: DATA_W]),
      .busy       (busy_w[p]),
      .pop        (bus.hold_pop[p]),
      .head_valid (prio_w[p]),
      .head_cmd   (cmd_w[p*CMD_W +: CMD_W]),
      .head_data1 (d1_w[p*DATA_W +: DATA_W]),
      .head_data2 (d2_w[p*DATA_W +: DATA_W]),
      .err        (err_w[p])
    );
  end

  assign bus.req_busy      = busy_w;
  assign bus.hold_prio_req = prio_w;
  assign bus.err_flag      = err_w;
  assign bus.hold_cmd      = cmd_w;
  assign bus.hold_data1    = d1_w;
  assign bus.hold_data2    = d2_w;

endmodule

// File: tb/tb_holdreg_mq.sv
// tb/tb_holdreg_mq.sv - directed self-checking bench for holdreg_mq
//
// Purpose : drives directed request/pop sequences and compares the head,
//           busy and error outputs against hand-computed values.
// Ports   : none (top-level bench).
module tb_holdreg_mq;

  localparam int NP  = 4;
  localparam int CW  = 4;
  localparam int DW  = 32;
  localparam int DEP = 2;

  logic c_clk = 1'b0;
  logic reset = 1'b1;

  logic [NP*CW-1:0] cmd_v  = '0;
  logic [NP*DW-1:0] data_v = '0;
  logic [NP-1:0]    pop_v  = '0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 c_clk = ~c_clk;

  holdreg_mq_if #(.NUM_PORTS(NP), .CMD_W(CW), .DATA_W(DW)) bus ();

  assign bus.req_cmd_in  = cmd_v;
  assign bus.req_data_in = data_v;
  assign bus.hold_pop    = pop_v;

  holdreg_mq #(
    .NUM_PORTS (NP),
    .CMD_W     (CW),
    .DATA_W    (DW),
    .DEPTH     (DEP)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [CW-1:0] c, input logic [DW-1:0] d);
    cmd_v[p*CW +: CW]  = c;
    data_v[p*DW +: DW] = d;
  endtask

  task automatic chk_head(input string tag, input int p, input logic v,
                          input logic [CW-1:0] c, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2);
    chk({tag, "_prio"},  128'(bus.hold_prio_req[p]), 128'(v));
    chk({tag, "_cmd"},   128'(bus.hold_cmd[p*CW +: CW]), 128'(c));
    chk({tag, "_data1"}, 128'(bus.hold_data1[p*DW +: DW]), 128'(d1));
    chk({tag, "_data2"}, 128'(bus.hold_data2[p*DW +: DW]), 128'(d2));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_prio"},  128'(bus.hold_prio_req), 128'(0));
    chk({tag, "_busy"},  128'(bus.req_busy), 128'(0));
    chk({tag, "_err"},   128'(bus.err_flag), 128'(0));
    chk({tag, "_cmd"},   128'(bus.hold_cmd), 128'(0));
    chk({tag, "_data1"}, bus.hold_data1, 128'(0));
    chk({tag, "_data2"}, bus.hold_data2, 128'(0));
  endtask

  initial begin
    // Reset held for three cycles, then idle with no commands.
    repeat (3) @(posedge c_clk);
    #1;
    chk_idle("reset_hold");
    reset = 1'b0;
    tick();
    chk_idle("idle_1");
    tick();
    chk_idle("idle_2");

    // Single capture on port 0: head appears two edges after cmd.
    drive(0, 4'd1, 32'd10);
    tick();
    chk("p0_op2_no_prio", 128'(bus.hold_prio_req[0]), 128'(0));
    drive(0, 4'd0, 32'd12);
    tick();
    drive(0, 4'd0, 32'd0);
    chk_head("p0_head", 0, 1'b1, 4'd1, 32'd10, 32'd12);
    pop_v[0] = 1'b1;
    tick();
    pop_v[0] = 1'b0;
    chk_head("p0_popped", 0, 1'b0, 4'd0, 32'd0, 32'd0);

    // Fill port 1 to DEPTH, then overflow attempt.
    drive(1, 4'd2, 32'd15);
    tick();
    chk("p1_busy_a", 128'(bus.req_busy[1]), 128'(0));
    drive(1, 4'd0, 32'd16);
    tick();
    chk("p1_busy_b", 128'(bus.req_busy[1]), 128'(0));
    drive(1, 4'd3, 32'd20);
    tick();
    chk("p1_busy_data2", 128'(bus.req_busy[1]), 128'(1));
    drive(1, 4'd0, 32'd21);
    tick();
    chk("p1_busy_full", 128'(bus.req_busy[1]), 128'(1));
    drive(1, 4'd4, 32'd22);
    tick();
    drive(1, 4'd0, 32'd0);
    chk("p1_err", 128'(bus.err_flag[1]), 128'(1));
    chk_head("p1_head_kept", 1, 1'b1, 4'd2, 32'd15, 32'd16);
    chk("p0_err_clean", 128'(bus.err_flag[0]), 128'(0));
    tick();
    chk("p1_still_full", 128'(bus.req_busy[1]), 128'(1));
    pop_v[1] = 1'b1;
    tick();
    pop_v[1] = 1'b0;
    chk_head("p1_second", 1, 1'b1, 4'd3, 32'd20, 32'd21);
    pop_v[1] = 1'b1;
    tick();
    pop_v[1] = 1'b0;
    chk_head("p1_empty", 1, 1'b0, 4'd0, 32'd0, 32'd0);

    // Port 2: push and pop in the same cycle with one entry queued.
    drive(2, 4'd7, 32'd40);
    tick();
    drive(2, 4'd0, 32'd41);
    tick();
    chk_head("p2_first", 2, 1'b1, 4'd7, 32'd40, 32'd41);
    drive(2, 4'd8, 32'd50);
    tick();
    chk("p2_prio_op2", 128'(bus.hold_prio_req[2]), 128'(1));
    drive(2, 4'd0, 32'd51);
    pop_v[2] = 1'b1;
    tick();
    pop_v[2] = 1'b0;
    drive(2, 4'd0, 32'd0);
    chk_head("p2_swapped", 2, 1'b1, 4'd8, 32'd50, 32'd51);
    chk("p2_not_busy", 128'(bus.req_busy[2]), 128'(0));
    pop_v[2] = 1'b1;
    tick();
    pop_v[2] = 1'b0;
    chk("p2_drained", 128'(bus.hold_prio_req[2]), 128'(0));

    // Port 3: non-zero cmd during the data2 cycle.
    drive(3, 4'd5, 32'd25);
    tick();
    drive(3, 4'd6, 32'd30);
    tick();
    drive(3, 4'd0, 32'd0);
    chk("p3_err", 128'(bus.err_flag[3]), 128'(1));
    chk_head("p3_head", 3, 1'b1, 4'd5, 32'd25, 32'd30);
    tick();
    chk_head("p3_head_stable", 3, 1'b1, 4'd5, 32'd25, 32'd30);
    pop_v[3] = 1'b1;
    tick();
    pop_v[3] = 1'b0;
    chk("p3_no_cmd6", 128'(bus.hold_prio_req[3]), 128'(0));
    tick();
    chk("p3_no_cmd6_later", 128'(bus.hold_prio_req[3]), 128'(0));

    // Asynchronous reset during an OP2 cycle with one entry queued on port 0.
    drive(0, 4'd9, 32'd60);
    tick();
    drive(0, 4'd0, 32'd61);
    tick();
    chk("p0_queued", 128'(bus.hold_prio_req[0]), 128'(1));
    drive(0, 4'd9, 32'd70);
    tick();
    chk("p0_busy_op2", 128'(bus.req_busy[0]), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async_reset");
    drive(0, 4'd0, 32'd71);
    tick();
    #2;
    reset = 1'b0;
    tick();
    chk_idle("post_reset_1");
    tick();
    chk_idle("post_reset_2");

    // Fresh request after reset behaves normally.
    drive(0, 4'd1, 32'd100);
    tick();
    drive(0, 4'd0, 32'd101);
    tick();
    drive(0, 4'd0, 32'd0);
    chk_head("p0_fresh", 0, 1'b1, 4'd1, 32'd100, 32'd101);
    chk("p0_fresh_err", 128'(bus.err_flag), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
